// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, redirect priority codes and default width.
package pc_seq_pkg;

    localparam int PCSEQ_XLEN = 32;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        WAIT,
        HALT
    } seq_state_e;

    // Ordered so that a plain magnitude compare gives redirect precedence
    typedef enum logic [1:0] {
        PRI_NONE,
        PRI_JMP,
        PRI_BR,
        PRI_TRAP
    } redir_pri_e;

endpackage

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Combinational redirect priority mux (trap > branch > jump) plus the merge of a live
// redirect against the one already pending while instruction memory is busy.
module redirect_arbiter
    import pc_seq_pkg::*;
#(
    parameter int XLEN = PCSEQ_XLEN
) (
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_tgt,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            pend_vld,
    input  redir_pri_e      pend_pri,
    input  logic [XLEN-1:0] pend_tgt,
    output logic            redir_vld,
    output redir_pri_e      redir_pri,
    output logic [XLEN-1:0] redir_tgt,
    output logic            sel_vld,
    output redir_pri_e      sel_pri,
    output logic [XLEN-1:0] sel_tgt
);

    logic [XLEN-1:0] raw_tgt;
    redir_pri_e      pend_eff;

    always_comb begin
        redir_pri = PRI_NONE;
        raw_tgt   = '0;
        if (trap_en) begin
            redir_pri = PRI_TRAP;
            raw_tgt   = trap_tgt;
        end else if (br_taken) begin
            redir_pri = PRI_BR;
            raw_tgt   = br_target;
        end else if (jmp_en) begin
            redir_pri = PRI_JMP;
            raw_tgt   = jmp_target;
        end
    end

    assign redir_vld = (redir_pri != PRI_NONE);
    assign redir_tgt = raw_tgt & {{(XLEN-2){1'b1}}, 2'b00};
    assign pend_eff  = pend_vld ? pend_pri : PRI_NONE;

    // A live redirect of equal priority replaces the pending one; a weaker one is dropped
    always_comb begin
        if (redir_vld && (redir_pri >= pend_eff)) begin
            sel_pri = redir_pri;
            sel_tgt = redir_tgt;
        end else begin
            sel_pri = pend_eff;
            sel_tgt = pend_tgt;
        end
    end

    assign sel_vld = (sel_pri != PRI_NONE);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection, stall/wait hold, pending redirects and HALT.
// Define PCSEQ_TRAP_EN to enable trap redirects to TRAP_VEC with EPC capture.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN     = PCSEQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h100,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            halt_req,
    input  logic            trap_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] npc,
    output logic            if_valid,
    output logic            flush_if,
    output logic [XLEN-1:0] trap_epc
);

    seq_state_e      state, nstate;
    logic [XLEN-1:0] pc;
    logic            pend_vld;
    redir_pri_e      pend_pri;
    logic [XLEN-1:0] pend_tgt;
    logic            pend_load, pend_clr;
    logic            trap_req;
    logic            redir_vld, sel_vld;
    redir_pri_e      redir_pri, sel_pri;
    logic [XLEN-1:0] redir_tgt, sel_tgt;

`ifdef PCSEQ_TRAP_EN
    logic [XLEN-1:0] epc;

    assign trap_req = trap_en && (state != BOOT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epc <= '0;
        end else if (trap_req) begin
            epc <= pc;
        end
    end

    assign trap_epc = epc;
`else
    logic unused_trap;

    assign unused_trap = trap_en;
    assign trap_req    = 1'b0;
    assign trap_epc    = '0;
`endif

    redirect_arbiter #(
        .XLEN(XLEN)
    ) u_arb (
        .trap_en   (trap_req),
        .trap_tgt  (TRAP_VEC),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_en    (jmp_en),
        .jmp_target(jmp_target),
        .pend_vld  (pend_vld),
        .pend_pri  (pend_pri),
        .pend_tgt  (pend_tgt),
        .redir_vld (redir_vld),
        .redir_pri (redir_pri),
        .redir_tgt (redir_tgt),
        .sel_vld   (sel_vld),
        .sel_pri   (sel_pri),
        .sel_tgt   (sel_tgt)
    );

    assign imem_addr = pc;

    always_comb begin
        nstate    = state;
        npc       = pc;
        if_valid  = 1'b0;
        flush_if  = 1'b0;
        pend_load = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            BOOT: begin
                npc    = RESET_PC;
                nstate = RUN;
            end
            RUN: begin
                if (redir_vld && imem_ready) begin
                    npc      = redir_tgt;
                    flush_if = 1'b1;
                end else if (redir_vld) begin
                    pend_load = 1'b1;
                    nstate    = WAIT;
                end else if (halt_req) begin
                    nstate = HALT;
                end else if (!imem_ready) begin
                    nstate = WAIT;
                end else if (!stall) begin
                    npc      = pc + XLEN'(PC_STEP);
                    if_valid = 1'b1;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    nstate   = RUN;
                    pend_clr = 1'b1;
                    if (sel_vld) begin
                        npc      = sel_tgt;
                        flush_if = 1'b1;
                    end
                end else if (redir_vld) begin
                    pend_load = 1'b1;
                end
            end
            HALT: begin
                // Only a trap can leave HALT; branches and jumps are ignored here
                if (redir_pri == PRI_TRAP) begin
                    npc      = redir_tgt;
                    flush_if = 1'b1;
                    nstate   = RUN;
                end
            end
            default: nstate = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            pend_vld <= 1'b0;
            pend_pri <= PRI_NONE;
            pend_tgt <= '0;
        end else begin
            state    <= nstate;
            pc       <= npc;
            imem_req <= (nstate == RUN) || (nstate == WAIT);
            if (pend_clr) begin
                pend_vld <= 1'b0;
                pend_pri <= PRI_NONE;
            end else if (pend_load) begin
                pend_vld <= sel_vld;
                pend_pri <= sel_pri;
                pend_tgt <= sel_tgt;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle behavioural model plus directed literal checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_en = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        halt_req = 1'b0;
    logic        trap_en = 1'b0;
    logic        imem_req, if_valid, flush_if;
    logic [31:0] imem_addr, npc, trap_epc;

    int checks = 0;
    int passes = 0;

    localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    int          m_mode = M_BOOT;
    logic [31:0] m_pc = '0;
    int          m_pend = 0;
    logic [31:0] m_pend_tgt = '0;
    logic [31:0] m_epc = '0;
    int          n_mode = M_BOOT;
    logic [31:0] n_pc = '0;
    int          n_pend = 0;
    logic [31:0] n_pend_tgt = '0;
    logic [31:0] n_epc = '0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .imem_ready(imem_ready),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jmp_en    (jmp_en),
        .jmp_target(jmp_target),
        .halt_req  (halt_req),
        .trap_en   (trap_en),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .npc       (npc),
        .if_valid  (if_valid),
        .flush_if  (flush_if),
        .trap_epc  (trap_epc)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic rdy, input logic stl, input logic br, input logic [31:0] brt,
                                 input logic jp, input logic [31:0] jpt, input logic hlt, input logic trp);
        @(posedge clk);
        #1;
        imem_ready = rdy;
        stall      = stl;
        br_taken   = br;
        br_target  = brt;
        jmp_en     = jp;
        jmp_target = jpt;
        halt_req   = hlt;
        trap_en    = trp;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Model: derive the expected outputs from the current inputs, then stage the next state
    always @(negedge clk) begin
        int          live_pri;
        logic [31:0] live_tgt;
        logic [31:0] e_npc;
        logic        e_valid, e_flush, e_req;
        live_pri = 0;
        live_tgt = '0;
        if (jmp_en) begin live_pri = 1; live_tgt = jmp_target & ~32'h3; end
        if (br_taken) begin live_pri = 2; live_tgt = br_target & ~32'h3; end
`ifdef PCSEQ_TRAP_EN
        if (trap_en && m_mode != M_BOOT) begin live_pri = 3; live_tgt = 32'h100; end
`endif
        e_req      = (m_mode == M_RUN) || (m_mode == M_WAIT);
        e_npc      = m_pc;
        e_valid    = 1'b0;
        e_flush    = 1'b0;
        n_mode     = m_mode;
        n_pend     = m_pend;
        n_pend_tgt = m_pend_tgt;
        n_epc      = (live_pri == 3) ? m_pc : m_epc;
        if (m_mode == M_BOOT) begin
            e_npc  = 32'h0;
            n_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (live_pri > 0 && imem_ready) begin e_npc = live_tgt; e_flush = 1'b1; end
            else if (live_pri > 0) begin n_pend = live_pri; n_pend_tgt = live_tgt; n_mode = M_WAIT; end
            else if (halt_req) n_mode = M_HALT;
            else if (!imem_ready) n_mode = M_WAIT;
            else if (!stall) begin e_npc = m_pc + 32'd4; e_valid = 1'b1; end
        end else if (m_mode == M_WAIT) begin
            if (imem_ready) begin
                n_mode = M_RUN;
                n_pend = 0;
                if (live_pri > 0 && live_pri >= m_pend) begin e_npc = live_tgt; e_flush = 1'b1; end
                else if (m_pend > 0) begin e_npc = m_pend_tgt; e_flush = 1'b1; end
            end else if (live_pri > 0 && live_pri >= m_pend) begin
                n_pend = live_pri;
                n_pend_tgt = live_tgt;
            end
        end else if (live_pri == 3) begin
            e_npc   = live_tgt;
            e_flush = 1'b1;
            n_mode  = M_RUN;
        end
        n_pc = e_npc;
        checkOutput("model_imem_req", imem_req, e_req);
        checkOutput("model_imem_addr", imem_addr, m_pc);
        checkOutput("model_npc", npc, e_npc);
        checkOutput("model_if_valid", if_valid, e_valid);
        checkOutput("model_flush_if", flush_if, e_flush);
        checkOutput("model_trap_epc", trap_epc, m_epc);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_BOOT; m_pc = '0; m_pend = 0; m_pend_tgt = '0; m_epc = '0;
        end else begin
            m_mode = n_mode; m_pc = n_pc; m_pend = n_pend; m_pend_tgt = n_pend_tgt; m_epc = n_epc;
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_req", imem_req, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", if_valid, 32'h0);
        checkOutput("rst_npc", npc, 32'h0);

        @(posedge clk); #1; imem_ready = 1'b1; reset_n = 1'b1;
        @(negedge clk);
        checkOutput("boot_req", imem_req, 32'h0);
        checkOutput("boot_addr", imem_addr, 32'h0);

        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("seq_addr", imem_addr, 32'(i * 4));
            checkOutput("seq_valid", if_valid, 32'h1);
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("stall_addr", imem_addr, 32'h10);
            checkOutput("stall_valid", if_valid, 32'h0);
            checkOutput("stall_req", imem_req, 32'h1);
        end
        idle();
        checkOutput("unstall_npc", npc, 32'h14);
        idle();
        checkOutput("unstall_addr", imem_addr, 32'h14);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0);
        checkOutput("brjmp_npc", npc, 32'h200);
        checkOutput("brjmp_flush", flush_if, 32'h1);
        idle();
        checkOutput("brjmp_addr", imem_addr, 32'h200);
        checkOutput("brjmp_flush_drop", flush_if, 32'h0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h307, 1'b0, 1'b0);
        checkOutput("jmp_mask_npc", npc, 32'h304);
        checkOutput("jmp_over_stall_flush", flush_if, 32'h1);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("nready_addr", imem_addr, 32'h40);
        checkOutput("nready_valid", if_valid, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
        checkOutput("wait_req", imem_req, 32'h1);
        checkOutput("wait_addr", imem_addr, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b0, 1'b0);
        idle();
        checkOutput("pend_npc", npc, 32'h90);
        checkOutput("pend_flush", flush_if, 32'h1);
        checkOutput("pend_valid", if_valid, 32'h0);
        idle();
        checkOutput("pend_addr", imem_addr, 32'h90);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle();
        checkOutput("wrap_npc", npc, 32'h0);
        idle();
        checkOutput("wrap_addr", imem_addr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("halt_npc", npc, 32'h4);
        idle();
        checkOutput("halt_req_low", imem_req, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        checkOutput("halt_frozen", imem_addr, 32'h4);

        @(posedge clk); #1; reset_n = 1'b0;
        @(negedge clk);
        checkOutput("halt_rst_addr", imem_addr, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        idle();
        idle();
        idle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("redir_halt_npc", npc, 32'h500);
        idle();
        checkOutput("redir_halt_req", imem_req, 32'h1);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1; reset_n = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        idle();
        idle();
        checkOutput("wait_rst_addr", imem_addr, 32'h4);
        checkOutput("wait_rst_flush", flush_if, 32'h0);

`ifdef PCSEQ_TRAP_EN
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h58, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle();
        checkOutput("trap_halted", imem_req, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("trap_npc", npc, 32'h100);
        idle();
        checkOutput("trap_addr", imem_addr, 32'h100);
        checkOutput("trap_epc", trap_epc, 32'h58);
        checkOutput("trap_run", imem_req, 32'h1);
`endif

        idle();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
